// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the CPU (read/write)
// and a read-only I/O requester. The CPU has fixed priority. I/O wins the next
// contention after MAX_WAIT consecutive denied cycles. In-flight reads are
// tagged with their owner so each side gets its own read-valid strobe.
module ram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic       OWNER_CPU  = 1'b0;
  localparam logic       OWNER_IO   = 1'b1;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic              cpu_win_s;
  logic              io_win_s;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_own_q, tag_own_d;

  // Pick the winner for this cycle; nothing is granted while Reset is high.
  always_comb begin
    cpu_win_s = 1'b0;
    io_win_s  = 1'b0;
    if (Reset) begin
      cpu_win_s = 1'b0;
      io_win_s  = 1'b0;
    end else if (cpu_req && io_req) begin
      if (wait_cnt_q == MAX_WAIT_C) begin
        io_win_s = 1'b1;
      end else begin
        cpu_win_s = 1'b1;
      end
    end else if (cpu_req) begin
      cpu_win_s = 1'b1;
    end else if (io_req) begin
      io_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
      io_win_s  = 1'b0;
    end
  end

  // Steer the winner onto the RAM port; an idle port drives all zeros.
  always_comb begin
    cpu_gnt   = cpu_win_s;
    io_gnt    = io_win_s;
    ram_addr  = {ADDR_W{1'b0}};
    ram_we    = 1'b0;
    ram_wdata = {DATA_W{1'b0}};
    if (cpu_win_s) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (io_win_s) begin
      ram_addr  = io_addr;
      ram_we    = 1'b0;
      ram_wdata = {DATA_W{1'b0}};
    end else begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_we    = 1'b0;
      ram_wdata = {DATA_W{1'b0}};
    end
  end

  // Count consecutive denied I/O cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!io_req || io_win_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q >= MAX_WAIT_C) begin
      wait_cnt_d = MAX_WAIT_C;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Shift the read-tag pipeline; the new entry records who issued the read.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = (cpu_win_s && !cpu_we) || io_win_s;
    tag_own_d[0] = io_win_s ? OWNER_IO : OWNER_CPU;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // State registers; reset drops any in-flight read tags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt_q <= 4'd0;
      tag_vld_q  <= {RD_LAT{1'b0}};
      tag_own_q  <= {RD_LAT{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
    end
  end

  // Route returning read data to the owner of the oldest tag; others see 0.
  always_comb begin
    cpu_rvalid = tag_vld_q[RD_LAT-1] && (tag_own_q[RD_LAT-1] == OWNER_CPU);
    io_rvalid  = tag_vld_q[RD_LAT-1] && (tag_own_q[RD_LAT-1] == OWNER_IO);
    if (cpu_rvalid) begin
      cpu_rdata = ram_rdata;
    end else begin
      cpu_rdata = {DATA_W{1'b0}};
    end
    if (io_rvalid) begin
      io_rdata = ram_rdata;
    end else begin
      io_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model (grant rule, denied-cycle count,
// queue of expected read returns, shadow memory).
module tb_ram_port_arbiter;

  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        io_req, io_gnt, io_rvalid;
  logic [15:0] io_addr, io_rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_addr(io_addr), .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .io_rdata(io_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h01:   return 16'h00AA;
      8'h02:   return 16'h00BB;
      default: return 16'(a) * 16'd37 + 16'h1000;
    endcase
  endfunction

  // Write-first RAM with RD_LAT read latency; contents restored while in reset.
  logic [15:0] ram_mem [0:255];
  logic [15:0] rd_pipe [0:RD_LAT-1];
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(8'(i));
    end else if (ram_we) begin
      ram_mem[ram_addr[7:0]] <= ram_wdata;
    end
    rd_pipe[0] <= ram_we ? ram_wdata : ram_mem[ram_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    logic        to_io;
    logic [15:0] data;
    int          due;
  } rd_t;
  rd_t         pend[$];
  logic [15:0] ref_mem [0:255];
  int          denied;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  int          io_gnt_cnt;
  logic        last_cg, last_ig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    denied = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"},    {31'd0, cpu_gnt},    32'd0);
    chk({tag, "_io_gnt"},     {31'd0, io_gnt},     32'd0);
    chk({tag, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
    chk({tag, "_io_rvalid"},  {31'd0, io_rvalid},  32'd0);
    chk({tag, "_cpu_rdata"},  {16'd0, cpu_rdata},  32'd0);
    chk({tag, "_io_rdata"},   {16'd0, io_rdata},   32'd0);
    chk({tag, "_ram_addr"},   {16'd0, ram_addr},   32'd0);
    chk({tag, "_ram_we"},     {31'd0, ram_we},     32'd0);
    chk({tag, "_ram_wdata"},  {16'd0, ram_wdata},  32'd0);
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance.
  task automatic step(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                      input logic [15:0] c_wd, input logic i_req, input logic [15:0] i_addr);
    logic        exp_cg, exp_ig, exp_cv, exp_iv;
    logic [15:0] exp_addr, exp_cd, exp_id;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    io_req = i_req; io_addr = i_addr;
    #4;
    exp_cg   = c_req && (!i_req || denied < MAX_WAIT);
    exp_ig   = i_req && !exp_cg;
    exp_addr = exp_cg ? c_addr : (exp_ig ? i_addr : 16'h0000);
    exp_cv = 1'b0; exp_iv = 1'b0; exp_cd = 16'h0000; exp_id = 16'h0000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].to_io) begin exp_iv = 1'b1; exp_id = pend[0].data; end
      else begin exp_cv = 1'b1; exp_cd = pend[0].data; end
      void'(pend.pop_front());
    end
    chk("cpu_gnt",    {31'd0, cpu_gnt},    {31'd0, exp_cg});
    chk("io_gnt",     {31'd0, io_gnt},     {31'd0, exp_ig});
    chk("ram_we",     {31'd0, ram_we},     {31'd0, exp_cg && c_we});
    chk("ram_addr",   {16'd0, ram_addr},   {16'd0, exp_addr});
    chk("ram_wdata",  {16'd0, ram_wdata},  {16'd0, (exp_cg ? c_wd : 16'h0000)});
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_cv});
    chk("io_rvalid",  {31'd0, io_rvalid},  {31'd0, exp_iv});
    chk("cpu_rdata",  {16'd0, cpu_rdata},  {16'd0, exp_cd});
    chk("io_rdata",   {16'd0, io_rdata},   {16'd0, exp_id});
    chk("rvalid_excl", {31'd0, cpu_rvalid & io_rvalid}, 32'd0);
    if (io_gnt) io_gnt_cnt++;
    // advance the model
    if (exp_cg && c_we) ref_mem[c_addr[7:0]] = c_wd;
    if (exp_cg && !c_we) pend.push_back('{1'b0, ref_mem[c_addr[7:0]], cyc + RD_LAT});
    if (exp_ig) pend.push_back('{1'b1, ref_mem[i_addr[7:0]], cyc + RD_LAT});
    if (i_req && !exp_ig) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
    else denied = 0;
    last_cg = exp_cg; last_ig = exp_ig;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  logic        cr, cw, ir;
  logic [15:0] ca, cd, ia;

  initial begin
    cyc = 0; io_gnt_cnt = 0; last_cg = 1'b0; last_ig = 1'b0;
    // Reset with requests asserted: everything must read as zero.
    Reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 16'hA5A5;
    io_req = 1'b1; io_addr = 16'h0066;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    cpu_req = 1'b0; io_req = 1'b0; cpu_we = 1'b0;
    Reset = 1'b0;

    // CPU read of a known location, then let the data return.
    step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Write then read back the same address in consecutive grants.
    step(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Continuous contention: I/O should get every fifth slot.
    io_gnt_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0040);
    chk("contention_io_cnt", io_gnt_cnt, 32'd2);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Alternating CPU/I-O reads: strobes alternate with matching data.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002);
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Randomized traffic; a denied request is held until granted.
    cr = 1'b0; cw = 1'b0; ca = 16'h0; cd = 16'h0; ir = 1'b0; ia = 16'h0;
    for (int i = 0; i < 300; i++) begin
      if (!(cr && !last_cg)) begin
        cr = 1'($urandom_range(0, 1));
        cw = 1'($urandom_range(0, 1));
        ca = 16'($urandom_range(0, 15));
        cd = 16'($urandom);
      end
      if (!(ir && !last_ig)) begin
        ir = 1'($urandom_range(0, 1));
        ia = 16'($urandom_range(0, 15));
      end
      step(cr, cw, ca, cd, ir, ia);
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Reset while a CPU read is in flight: the read must never return.
    step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    cpu_req = 1'b0;
    Reset = 1'b1;
    #1;
    chk_all_zero("reset_mid_read");
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Idle port.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // A fresh contention after idle must again start with four CPU grants.
    io_gnt_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0004);
    chk("post_idle_io_cnt", io_gnt_cnt, 32'd0);
    step(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0004);
    chk("post_idle_io_cnt5", io_gnt_cnt, 32'd1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
